// File: rtl/mips_wb_trace_capture.sv
`default_nettype none
// ============================================================================
// Module : mips_wb_trace_capture
// Snoops mips_16 WB register writes into a timestamped FWFT trace FIFO and
// keeps a shadow copy of the 8x16 register file.
// Rev    : 1.0  initial release
// ============================================================================
module mips_wb_trace_capture #(
    parameter int DEPTH  = 16,
    parameter int CYC_W  = 16,
    parameter int DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     capture_en,
    input  logic                     flush,
    input  logic                     reg_write_en,
    input  logic [2:0]               reg_write_dest,
    input  logic [15:0]              reg_write_data,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [2:0]               trace_dest,
    output logic [15:0]              trace_data,
    output logic [CYC_W-1:0]         trace_cycle,
    output logic [$clog2(DEPTH):0]   trace_count,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_cnt,
    input  logic [2:0]               shadow_addr,
    output logic [15:0]              shadow_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]         C_FULL     = DEPTH[AW:0];
    localparam logic [AW:0]         C_CNT_ONE  = 1;
    localparam logic [AW-1:0]       C_PTR_ONE  = 1;
    localparam logic [CYC_W-1:0]    C_CYC_ONE  = 1;
    localparam logic [DROP_W-1:0]   C_DROP_ONE = 1;
    localparam logic [DROP_W-1:0]   C_DROP_MAX = '1;

    logic [CYC_W-1:0]  r_cyc;
    logic [2:0]        r_mem_dest  [DEPTH];
    logic [15:0]       r_mem_data  [DEPTH];
    logic [CYC_W-1:0]  r_mem_cyc   [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_count;
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop;
    logic [2:0]        r_last_dest;
    logic [15:0]       r_last_data;
    logic [CYC_W-1:0]  r_last_cyc;
    logic [15:0]       r_shadow    [8];

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_accept;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == C_FULL);
    assign w_push   = reg_write_en & capture_en & ~flush;
    assign w_pop    = trace_ready & ~w_empty & ~flush;
    // When full, a same-cycle pop frees the slot the push lands in (wptr == rptr).
    assign w_accept = w_push & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc <= '0;
        end else begin
            r_cyc <= r_cyc + C_CYC_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop     <= '0;
        end else if (flush) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop     <= '0;
        end else begin
            if (w_accept) r_wptr <= r_wptr + C_PTR_ONE;
            if (w_pop)    r_rptr <= r_rptr + C_PTR_ONE;
            if (w_accept && !w_pop)      r_count <= r_count + C_CNT_ONE;
            else if (!w_accept && w_pop) r_count <= r_count - C_CNT_ONE;
            if (w_push && !w_accept) begin
                r_overflow <= 1'b1;
                if (r_drop != C_DROP_MAX) r_drop <= r_drop + C_DROP_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_mem_dest[r_wptr] <= reg_write_dest;
            r_mem_data[r_wptr] <= reg_write_data;
            r_mem_cyc[r_wptr]  <= r_cyc;
        end
    end

    // Last-popped head is held so the outputs stay put once the FIFO drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_dest <= '0;
            r_last_data <= '0;
            r_last_cyc  <= '0;
        end else if (w_pop) begin
            r_last_dest <= r_mem_dest[r_rptr];
            r_last_data <= r_mem_data[r_rptr];
            r_last_cyc  <= r_mem_cyc[r_rptr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) r_shadow[i] <= '0;
        end else if (reg_write_en && reg_write_dest != 3'd0) begin
            r_shadow[reg_write_dest] <= reg_write_data;
        end
    end

    assign trace_valid = ~w_empty;
    assign trace_dest  = w_empty ? r_last_dest : r_mem_dest[r_rptr];
    assign trace_data  = w_empty ? r_last_data : r_mem_data[r_rptr];
    assign trace_cycle = w_empty ? r_last_cyc  : r_mem_cyc[r_rptr];
    assign trace_count = r_count;
    assign overflow    = r_overflow;
    assign drop_cnt    = r_drop;
    assign shadow_data = r_shadow[shadow_addr];

endmodule
`default_nettype wire

// File: tb/tb_mips_wb_trace_capture.sv
`default_nettype none
// ============================================================================
// Module : tb_mips_wb_trace_capture
// Directed self-checking bench for the WB trace capture block.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mips_wb_trace_capture;

    typedef struct packed {
        logic [2:0]  d;
        logic [15:0] v;
        logic [15:0] c;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        capture_en = 1'b1;
    logic        flush = 1'b0;
    logic        reg_write_en = 1'b0;
    logic [2:0]  reg_write_dest = '0;
    logic [15:0] reg_write_data = '0;
    logic        trace_valid;
    logic        trace_ready = 1'b1;
    logic [2:0]  trace_dest;
    logic [15:0] trace_data;
    logic [15:0] trace_cycle;
    logic [4:0]  trace_count;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic [2:0]  shadow_addr = '0;
    logic [15:0] shadow_data;

    int          total = 0;
    int          bad = 0;
    logic [15:0] cyc = '0;
    ent_t        q[$];

    mips_wb_trace_capture #(.DEPTH(16), .CYC_W(16), .DROP_W(8)) dut (
        .clk(clk), .rst(rst), .capture_en(capture_en), .flush(flush),
        .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest),
        .reg_write_data(reg_write_data), .trace_valid(trace_valid),
        .trace_ready(trace_ready), .trace_dest(trace_dest), .trace_data(trace_data),
        .trace_cycle(trace_cycle), .trace_count(trace_count), .overflow(overflow),
        .drop_cnt(drop_cnt), .shadow_addr(shadow_addr), .shadow_data(shadow_data)
    );

    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        if (rst) cyc = 16'd0;
        else     cyc = cyc + 16'd1;
        #1;
    endtask

    // One WB write; the expected entry carries the cycle stamp of the WB cycle.
    task automatic wb(input logic [2:0] d, input logic [15:0] v, input logic cap);
        ent_t e;
        e = '{d: d, v: v, c: cyc};
        reg_write_en = 1'b1; reg_write_dest = d; reg_write_data = v; capture_en = cap;
        tick();
        reg_write_en = 1'b0; capture_en = 1'b1;
        if (cap && !flush && q.size() < 16) q.push_back(e);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; trace_ready = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({trace_valid, trace_count, overflow, drop_cnt} !== 15'd0) begin
            bad++; $display("FAIL reset_status: got %h expected 0", {trace_valid, trace_count, overflow, drop_cnt});
        end
        total++;
        if ({trace_dest, trace_data, trace_cycle} !== 35'd0) begin
            bad++; $display("FAIL reset_head: got %h expected 0", {trace_dest, trace_data, trace_cycle});
        end
        for (int a = 0; a < 8; a++) begin
            shadow_addr = a[2:0]; #1;
            total++;
            if (shadow_data !== 16'd0) begin
                bad++; $display("FAIL reset_shadow r%0d: got %h expected 0000", a, shadow_data);
            end
        end
    endtask

    task automatic test_first_write();
        repeat (5) tick();
        wb(3'd3, 16'h1234, 1'b1);
        total++;
        if ({trace_valid, trace_dest, trace_data, trace_cycle} !== {1'b1, 3'd3, 16'h1234, 16'd5}) begin
            bad++; $display("FAIL first_head: got %h expected %h",
                            {trace_valid, trace_dest, trace_data, trace_cycle}, {1'b1, 3'd3, 16'h1234, 16'd5});
        end
        shadow_addr = 3'd3; #1;
        total++;
        if (shadow_data !== 16'h1234) begin
            bad++; $display("FAIL first_shadow: got %h expected 1234", shadow_data);
        end
        tick();
        q.pop_front();
        total++;
        if ({trace_valid, trace_count} !== 6'd0) begin
            bad++; $display("FAIL first_drained: got valid=%b count=%0d expected 0/0", trace_valid, trace_count);
        end
    endtask

    task automatic test_overflow_order();
        trace_ready = 1'b0;
        for (int i = 0; i < 17; i++) wb(i[2:0], 16'(16'hA000 + i), 1'b1);
        total++;
        if ({trace_count, overflow, drop_cnt} !== {5'd16, 1'b1, 8'd1}) begin
            bad++; $display("FAIL ovf_status: got count=%0d ovf=%b drop=%0d expected 16/1/1", trace_count, overflow, drop_cnt);
        end
        trace_ready = 1'b1;
        for (int n = 0; n < 20 && q.size() > 0; n++) begin
            total++;
            if ({trace_valid, trace_dest, trace_data, trace_cycle} !== {1'b1, q[0]}) begin
                bad++; $display("FAIL ovf_drain: got %h expected %h", {trace_valid, trace_dest, trace_data, trace_cycle}, {1'b1, q[0]});
            end
            tick();
            q.pop_front();
        end
        trace_ready = 1'b0;
        total++;
        if (trace_valid !== 1'b0) begin
            bad++; $display("FAIL ovf_empty: got valid=%b expected 0", trace_valid);
        end
    endtask

    task automatic test_full_push_pop();
        ent_t e;
        do_flush();
        trace_ready = 1'b0;
        for (int i = 0; i < 16; i++) wb(3'(i + 1), 16'(16'hB000 + i), 1'b1);
        total++;
        if ({trace_count, overflow} !== {5'd16, 1'b0}) begin
            bad++; $display("FAIL full_status: got count=%0d ovf=%b expected 16/0", trace_count, overflow);
        end
        e = '{d: 3'd6, v: 16'hC0DE, c: cyc};
        reg_write_en = 1'b1; reg_write_dest = 3'd6; reg_write_data = 16'hC0DE; trace_ready = 1'b1;
        tick();
        reg_write_en = 1'b0; trace_ready = 1'b0;
        q.pop_front();
        q.push_back(e);
        total++;
        if ({trace_count, overflow, drop_cnt} !== {5'd16, 1'b0, 8'd0}) begin
            bad++; $display("FAIL pushpop_status: got count=%0d ovf=%b drop=%0d expected 16/0/0", trace_count, overflow, drop_cnt);
        end
        trace_ready = 1'b1;
        for (int n = 0; n < 20 && q.size() > 0; n++) begin
            total++;
            if ({trace_valid, trace_dest, trace_data, trace_cycle} !== {1'b1, q[0]}) begin
                bad++; $display("FAIL pushpop_drain: got %h expected %h", {trace_valid, trace_dest, trace_data, trace_cycle}, {1'b1, q[0]});
            end
            tick();
            q.pop_front();
        end
        trace_ready = 1'b0;
    endtask

    task automatic test_r0_capture_en();
        do_flush();
        wb(3'd0, 16'hFFFF, 1'b1);
        wb(3'd7, 16'hBEEF, 1'b0);
        shadow_addr = 3'd0; #1;
        total++;
        if (shadow_data !== 16'h0000) begin
            bad++; $display("FAIL r0_shadow: got %h expected 0000", shadow_data);
        end
        shadow_addr = 3'd7; #1;
        total++;
        if (shadow_data !== 16'hBEEF) begin
            bad++; $display("FAIL r7_shadow: got %h expected beef", shadow_data);
        end
        total++;
        if ({trace_count, trace_valid, trace_dest, trace_data, trace_cycle} !== {5'd1, 1'b1, q[0]}) begin
            bad++; $display("FAIL r0_fifo: got %h expected %h", {trace_count, trace_valid, trace_dest, trace_data, trace_cycle}, {5'd1, 1'b1, q[0]});
        end
    endtask

    task automatic test_flush_reset_mid_drain();
        do_flush();
        trace_ready = 1'b0;
        for (int i = 0; i < 17; i++) wb(3'(1 + i % 7), 16'(16'h5000 + i), 1'b1);
        trace_ready = 1'b1;
        tick(); tick();
        flush = 1'b1; reg_write_en = 1'b1; reg_write_dest = 3'd5; reg_write_data = 16'h5A5A;
        tick();
        flush = 1'b0; reg_write_en = 1'b0; trace_ready = 1'b0;
        q.delete();
        total++;
        if ({trace_valid, trace_count, overflow, drop_cnt} !== 15'd0) begin
            bad++; $display("FAIL flush_status: got %h expected 0", {trace_valid, trace_count, overflow, drop_cnt});
        end
        shadow_addr = 3'd5; #1;
        total++;
        if (shadow_data !== 16'h5A5A) begin
            bad++; $display("FAIL flush_shadow_r5: got %h expected 5a5a", shadow_data);
        end
        shadow_addr = 3'd1; #1;
        total++;
        if (shadow_data !== 16'h500E) begin
            bad++; $display("FAIL flush_shadow_r1: got %h expected 500e", shadow_data);
        end
        tick();
        total++;
        if (trace_valid !== 1'b0) begin
            bad++; $display("FAIL flush_no_capture: got valid=%b expected 0", trace_valid);
        end
        for (int i = 0; i < 5; i++) wb(3'd2, 16'(16'h6000 + i), 1'b1);
        trace_ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; trace_ready = 1'b0;
        q.delete();
        total++;
        if ({trace_valid, trace_count, overflow} !== 7'd0) begin
            bad++; $display("FAIL rst_status: got valid=%b count=%0d ovf=%b expected 0/0/0", trace_valid, trace_count, overflow);
        end
        for (int a = 0; a < 8; a++) begin
            shadow_addr = a[2:0]; #1;
            total++;
            if (shadow_data !== 16'd0) begin
                bad++; $display("FAIL rst_shadow r%0d: got %h expected 0000", a, shadow_data);
            end
        end
        tick();
        total++;
        if (trace_valid !== 1'b0) begin
            bad++; $display("FAIL rst_no_pulse: got valid=%b expected 0", trace_valid);
        end
    endtask

    task automatic test_saturate_rollover();
        trace_ready = 1'b0;
        for (int i = 0; i < 316; i++) wb(3'd4, 16'(i), 1'b1);
        total++;
        if ({trace_count, overflow, drop_cnt} !== {5'd16, 1'b1, 8'd255}) begin
            bad++; $display("FAIL sat_status: got count=%0d ovf=%b drop=%0d expected 16/1/255", trace_count, overflow, drop_cnt);
        end
        do_flush();
        total++;
        if ({overflow, drop_cnt} !== 9'd0) begin
            bad++; $display("FAIL sat_flush: got ovf=%b drop=%0d expected 0/0", overflow, drop_cnt);
        end
        for (int n = 0; n < 70000 && cyc != 16'hFFFF; n++) tick();
        wb(3'd1, 16'hAAAA, 1'b1);
        wb(3'd2, 16'hBBBB, 1'b1);
        total++;
        if ({trace_valid, trace_dest, trace_data, trace_cycle} !== {1'b1, 3'd1, 16'hAAAA, 16'hFFFF}) begin
            bad++; $display("FAIL roll_first: got %h expected %h", {trace_valid, trace_dest, trace_data, trace_cycle}, {1'b1, 3'd1, 16'hAAAA, 16'hFFFF});
        end
        trace_ready = 1'b1;
        tick();
        trace_ready = 1'b0;
        total++;
        if ({trace_valid, trace_dest, trace_data, trace_cycle} !== {1'b1, 3'd2, 16'hBBBB, 16'h0000}) begin
            bad++; $display("FAIL roll_second: got %h expected %h", {trace_valid, trace_dest, trace_data, trace_cycle}, {1'b1, 3'd2, 16'hBBBB, 16'h0000});
        end
    endtask

    initial begin
        test_reset();
        test_first_write();
        test_overflow_order();
        test_full_push_pop();
        test_r0_capture_en();
        test_flush_reset_mid_drain();
        test_saturate_rollover();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
